// File: rtl/decode_stage.sv
// decode_stage
//
// Registered decode stage sitting between the fetch buffer and issue.
// Fetched instructions are queued in a small FIFO; the head entry is
// decoded (RV32I/RV64I, M, Zicsr, privileged ops) and handed to issue
// through a valid/ready output register. Serialising instructions and
// trapping bundles stall further decode until the back end releases us.
//
// Optional feature macro: DECODE_PERF_CNT_EN adds decode/stall counters.
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   flush_i               pipeline flush, beats everything else
//   serialize_done_i      back end retired the pending serialising instr
//   if_valid_i/if_ready_o fetch handshake; if_ready_o is registered
//   if_instr_i/pc/fault   fetched word, its PC and fetch access fault
//   dec_valid_o/ready_i   issue handshake for the decoded bundle
//   dec_*                 decoded bundle fields
//   perf_dec_cnt_o       (DECODE_PERF_CNT_EN) bundles loaded
//   perf_stall_cnt_o     (DECODE_PERF_CNT_EN) cycles FIFO non-empty, no load
//
// Unit one-hot (bit): 0 ALU, 1 SHIFT, 2 BRANCH, 3 LSU, 4 MULDIV, 5 SYSTEM.
// Operation one-hot, meaning depends on the unit:
//   ALU    : 0 ADD  1 SUB  2 SLT  3 XOR  4 OR  5 AND
//   SHIFT  : 0 SLL  1 SRL  2 SRA
//   BRANCH : 0 JAL  1 JALR 2 BEQ  3 BNE  4 BLT 5 BGE  (all zero = AUIPC)
//   LSU    : 0 LOAD 1 STORE
//   MULDIV : 0 MUL  1 MULH 2 MULHSU 3 MULHU 4 DIV 5 REM
//   SYSTEM : 0 CSRRW 1 CSRRS 2 CSRRC 3 FENCE 4 XRET 5 WFI
// mret/sret are told apart by dec_csr_adr_o (instr[31:20]).
// NB_UNIT and NB_OPERATION are expected to be at least 6.

module decode_stage #(
  parameter int XLEN         = 32,
  parameter int IBUF_DEPTH   = 4,
  parameter int NB_UNIT      = 6,
  parameter int NB_OPERATION = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush_i,
  input  logic                    serialize_done_i,
  input  logic                    if_valid_i,
  output logic                    if_ready_o,
  input  logic [31:0]             if_instr_i,
  input  logic [XLEN-1:0]         if_pc_i,
  input  logic                    if_fault_i,
  output logic                    dec_valid_o,
  input  logic                    dec_ready_i,
  output logic [XLEN-1:0]         dec_pc_o,
  output logic                    dec_rd_v_o,
  output logic                    dec_rs1_v_o,
  output logic                    dec_rs2_v_o,
  output logic [4:0]              dec_rd_adr_o,
  output logic [4:0]              dec_rs1_adr_o,
  output logic [4:0]              dec_rs2_adr_o,
  output logic [XLEN-1:0]         dec_imm_o,
  output logic [NB_UNIT-1:0]      dec_unit_o,
  output logic [NB_OPERATION-1:0] dec_op_o,
  output logic [3:0]              dec_access_size_o,
  output logic                    dec_unsigned_o,
  output logic                    dec_word_op_o,
  output logic [11:0]             dec_csr_adr_o,
  output logic                    dec_exc_v_o,
  output logic [3:0]              dec_exc_cause_o
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]         perf_dec_cnt_o,
  output logic [XLEN-1:0]         perf_stall_cnt_o
`endif
);

  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(IBUF_DEPTH);
  localparam bit RV64 = (XLEN == 64);

  localparam int U_ALU = 0, U_SHIFT = 1, U_BRU = 2, U_LSU = 3, U_MUL = 4, U_SYS = 5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32= 7'b0011011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {RUN, SER_WAIT, TRAP_WAIT} state_t;

  state_t state, state_next;

  logic [31:0]           instr_mem [IBUF_DEPTH];
  logic [XLEN-1:0]       pc_mem    [IBUF_DEPTH];
  logic [IBUF_DEPTH-1:0] fault_mem;
  logic [PW-1:0]         head_ptr, tail_ptr;
  logic [CW-1:0]         count, count_next;
  logic                  fifo_empty, push, load;

  logic [31:0]     hi;
  logic [XLEN-1:0] hi_pc;
  logic            hi_fault;
  logic [6:0]      opcode, f7;
  logic [5:0]      f6;
  logic [2:0]      f3;
  logic [4:0]      rd, rs1, rs2;
  logic [63:0]     imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_sh5, imm_z;
  logic            shift_lo_ok, shift_ar_ok;

  logic                    d_rd_v, d_rs1_v, d_rs2_v;
  logic [63:0]             d_imm;
  logic [NB_UNIT-1:0]      d_unit;
  logic [NB_OPERATION-1:0] d_op;
  logic [3:0]              d_size;
  logic                    d_unsigned, d_word, illegal, is_ecall, is_ebreak, serial;
  logic [11:0]             d_csr;
  logic                    exc_v;
  logic [3:0]              exc_cause;

  assign fifo_empty = (count == '0);
  assign push       = if_valid_i && if_ready_o && !flush_i;
  // The output register only loads in RUN and when it is empty or being drained.
  assign load       = !fifo_empty && (state == RUN) && (!dec_valid_o || dec_ready_i) && !flush_i;
  assign count_next = count + CW'(push) - CW'(load);

  // FIFO storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_ptr] <= if_instr_i;
      pc_mem[tail_ptr]    <= if_pc_i;
      fault_mem[tail_ptr] <= if_fault_i;
    end
  end

  // Pointers and occupancy. if_ready_o is registered from the next count,
  // so a full FIFO refuses a push even while it pops in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      count      <= '0;
      if_ready_o <= 1'b1;
    end else if (flush_i) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      count      <= '0;
      if_ready_o <= 1'b1;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (load) head_ptr <= head_ptr + PW'(1);
      count      <= count_next;
      if_ready_o <= (count_next < DEPTH_CNT);
    end
  end

  assign hi       = instr_mem[head_ptr];
  assign hi_pc    = pc_mem[head_ptr];
  assign hi_fault = fault_mem[head_ptr];
  assign opcode   = hi[6:0];
  assign rd       = hi[11:7];
  assign f3       = hi[14:12];
  assign rs1      = hi[19:15];
  assign rs2      = hi[24:20];
  assign f7       = hi[31:25];
  assign f6       = hi[31:26];

  assign imm_i   = {{52{hi[31]}}, hi[31:20]};
  assign imm_s   = {{52{hi[31]}}, hi[31:25], hi[11:7]};
  assign imm_b   = {{51{hi[31]}}, hi[31], hi[7], hi[30:25], hi[11:8], 1'b0};
  assign imm_u   = {{32{hi[31]}}, hi[31:12], 12'b0};
  assign imm_j   = {{43{hi[31]}}, hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};
  assign imm_sh  = {58'b0, (RV64 ? hi[25:20] : {1'b0, hi[24:20]})};
  assign imm_sh5 = {59'b0, hi[24:20]};
  assign imm_z   = {59'b0, hi[19:15]};

  // RV64 shifts use a 6-bit shamt, so only funct7[6:1] is checked there;
  // on RV32 a set bit 25 makes the shift illegal.
  assign shift_lo_ok = RV64 ? (f6 == 6'b000000) : (f7 == 7'b0000000);
  assign shift_ar_ok = RV64 ? (f6 == 6'b010000) : (f7 == 7'b0100000);

  // Combinational decode of the FIFO head entry.
  always_comb begin
    d_rd_v     = 1'b0;
    d_rs1_v    = 1'b0;
    d_rs2_v    = 1'b0;
    d_imm      = '0;
    d_unit     = '0;
    d_op       = '0;
    d_size     = '0;
    d_unsigned = 1'b0;
    d_word     = 1'b0;
    d_csr      = '0;
    illegal    = 1'b0;
    is_ecall   = 1'b0;
    is_ebreak  = 1'b0;
    serial     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        d_unit[U_ALU] = 1'b1; d_op[0] = 1'b1; d_rd_v = 1'b1; d_imm = imm_u;
      end
      OPC_AUIPC: begin
        d_unit[U_BRU] = 1'b1; d_rd_v = 1'b1; d_imm = imm_u;
      end
      OPC_JAL: begin
        d_unit[U_BRU] = 1'b1; d_op[0] = 1'b1; d_rd_v = 1'b1; d_imm = imm_j;
      end
      OPC_JALR: begin
        d_unit[U_BRU] = 1'b1; d_op[1] = 1'b1; d_rd_v = 1'b1; d_rs1_v = 1'b1; d_imm = imm_i;
        illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        d_unit[U_BRU] = 1'b1; d_rs1_v = 1'b1; d_rs2_v = 1'b1; d_imm = imm_b;
        case (f3)
          3'b000: d_op[2] = 1'b1;
          3'b001: d_op[3] = 1'b1;
          3'b100: d_op[4] = 1'b1;
          3'b101: d_op[5] = 1'b1;
          3'b110: begin d_op[4] = 1'b1; d_unsigned = 1'b1; end
          3'b111: begin d_op[5] = 1'b1; d_unsigned = 1'b1; end
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d_unit[U_LSU] = 1'b1; d_op[0] = 1'b1; d_rd_v = 1'b1; d_rs1_v = 1'b1; d_imm = imm_i;
        case (f3)
          3'b000: d_size = 4'b0001;
          3'b001: d_size = 4'b0010;
          3'b010: d_size = 4'b0100;
          3'b011: begin d_size = 4'b1000; illegal = !RV64; end
          3'b100: begin d_size = 4'b0001; d_unsigned = 1'b1; end
          3'b101: begin d_size = 4'b0010; d_unsigned = 1'b1; end
          3'b110: begin d_size = 4'b0100; d_unsigned = 1'b1; illegal = !RV64; end
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        d_unit[U_LSU] = 1'b1; d_op[1] = 1'b1; d_rs1_v = 1'b1; d_rs2_v = 1'b1; d_imm = imm_s;
        case (f3)
          3'b000: d_size = 4'b0001;
          3'b001: d_size = 4'b0010;
          3'b010: d_size = 4'b0100;
          3'b011: begin d_size = 4'b1000; illegal = !RV64; end
          default: illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        d_rd_v = 1'b1; d_rs1_v = 1'b1; d_imm = imm_i; d_unit[U_ALU] = 1'b1;
        case (f3)
          3'b000: d_op[0] = 1'b1;
          3'b010: d_op[2] = 1'b1;
          3'b011: begin d_op[2] = 1'b1; d_unsigned = 1'b1; end
          3'b100: d_op[3] = 1'b1;
          3'b110: d_op[4] = 1'b1;
          3'b111: d_op[5] = 1'b1;
          3'b001: begin
            d_unit = '0; d_unit[U_SHIFT] = 1'b1; d_op[0] = 1'b1; d_imm = imm_sh;
            illegal = !shift_lo_ok;
          end
          default: begin
            d_unit = '0; d_unit[U_SHIFT] = 1'b1; d_imm = imm_sh;
            if (shift_lo_ok)      d_op[1] = 1'b1;
            else if (shift_ar_ok) d_op[2] = 1'b1;
            else                  illegal = 1'b1;
          end
        endcase
      end
      OPC_OPIMM32: begin
        d_rd_v = 1'b1; d_rs1_v = 1'b1; d_word = 1'b1; illegal = !RV64;
        case (f3)
          3'b000: begin d_unit[U_ALU] = 1'b1; d_op[0] = 1'b1; d_imm = imm_i; end
          3'b001: begin
            d_unit[U_SHIFT] = 1'b1; d_op[0] = 1'b1; d_imm = imm_sh5;
            if (f7 != 7'b0000000) illegal = 1'b1;
          end
          3'b101: begin
            d_unit[U_SHIFT] = 1'b1; d_imm = imm_sh5;
            if (f7 == 7'b0000000)      d_op[1] = 1'b1;
            else if (f7 == 7'b0100000) d_op[2] = 1'b1;
            else                       illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP: begin
        d_rd_v = 1'b1; d_rs1_v = 1'b1; d_rs2_v = 1'b1;
        if (f7 == 7'b0000001) begin
          d_unit[U_MUL] = 1'b1;
          case (f3)
            3'b000: d_op[0] = 1'b1;
            3'b001: d_op[1] = 1'b1;
            3'b010: d_op[2] = 1'b1;
            3'b011: d_op[3] = 1'b1;
            3'b100: d_op[4] = 1'b1;
            3'b101: begin d_op[4] = 1'b1; d_unsigned = 1'b1; end
            3'b110: d_op[5] = 1'b1;
            default: begin d_op[5] = 1'b1; d_unsigned = 1'b1; end
          endcase
        end else if (f7 == 7'b0000000) begin
          d_unit[U_ALU] = 1'b1;
          case (f3)
            3'b000: d_op[0] = 1'b1;
            3'b001: begin d_unit = '0; d_unit[U_SHIFT] = 1'b1; d_op[0] = 1'b1; end
            3'b010: d_op[2] = 1'b1;
            3'b011: begin d_op[2] = 1'b1; d_unsigned = 1'b1; end
            3'b100: d_op[3] = 1'b1;
            3'b101: begin d_unit = '0; d_unit[U_SHIFT] = 1'b1; d_op[1] = 1'b1; end
            3'b110: d_op[4] = 1'b1;
            default: d_op[5] = 1'b1;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          d_unit[U_ALU] = 1'b1; d_op[1] = 1'b1;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          d_unit[U_SHIFT] = 1'b1; d_op[2] = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP32: begin
        d_rd_v = 1'b1; d_rs1_v = 1'b1; d_rs2_v = 1'b1; d_word = 1'b1; illegal = !RV64;
        case ({f7, f3})
          {7'b0000000, 3'b000}: begin d_unit[U_ALU] = 1'b1; d_op[0] = 1'b1; end
          {7'b0100000, 3'b000}: begin d_unit[U_ALU] = 1'b1; d_op[1] = 1'b1; end
          {7'b0000000, 3'b001}: begin d_unit[U_SHIFT] = 1'b1; d_op[0] = 1'b1; end
          {7'b0000000, 3'b101}: begin d_unit[U_SHIFT] = 1'b1; d_op[1] = 1'b1; end
          {7'b0100000, 3'b101}: begin d_unit[U_SHIFT] = 1'b1; d_op[2] = 1'b1; end
          {7'b0000001, 3'b000}: begin d_unit[U_MUL] = 1'b1; d_op[0] = 1'b1; end
          {7'b0000001, 3'b100}: begin d_unit[U_MUL] = 1'b1; d_op[4] = 1'b1; end
          {7'b0000001, 3'b101}: begin d_unit[U_MUL] = 1'b1; d_op[4] = 1'b1; d_unsigned = 1'b1; end
          {7'b0000001, 3'b110}: begin d_unit[U_MUL] = 1'b1; d_op[5] = 1'b1; end
          {7'b0000001, 3'b111}: begin d_unit[U_MUL] = 1'b1; d_op[5] = 1'b1; d_unsigned = 1'b1; end
          default: illegal = 1'b1;
        endcase
      end
      OPC_MISC: begin
        d_unit[U_SYS] = 1'b1; d_op[3] = 1'b1; serial = 1'b1;
        illegal = (f3[2:1] != 2'b00);
      end
      OPC_SYSTEM: begin
        d_unit[U_SYS] = 1'b1; d_csr = hi[31:20];
        case (f3)
          3'b000: begin
            if (hi == 32'h0000_0073) is_ecall = 1'b1;
            else if (hi == 32'h0010_0073) is_ebreak = 1'b1;
            else if (hi == 32'h3020_0073 || hi == 32'h1020_0073) begin
              d_op[4] = 1'b1; serial = 1'b1;
            end else if (hi == 32'h1050_0073) d_op[5] = 1'b1;
            else if (f7 == 7'b0001001 && rd == 5'd0) begin
              d_op[3] = 1'b1; d_rs1_v = 1'b1; d_rs2_v = 1'b1; serial = 1'b1;
            end else illegal = 1'b1;
          end
          3'b100: illegal = 1'b1;
          default: begin
            d_rd_v = 1'b1; serial = 1'b1;
            // Immediate forms reuse the rs1 field as a 5-bit zero-extended value.
            if (f3[2]) d_imm = imm_z;
            else       d_rs1_v = 1'b1;
            case (f3[1:0])
              2'b01:   d_op[0] = 1'b1;
              2'b10:   d_op[1] = 1'b1;
              default: d_op[2] = 1'b1;
            endcase
          end
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign exc_v = hi_fault || illegal || is_ebreak || is_ecall;

  always_comb begin
    if (hi_fault)       exc_cause = 4'd1;
    else if (illegal)   exc_cause = 4'd2;
    else if (is_ebreak) exc_cause = 4'd3;
    else if (is_ecall)  exc_cause = 4'd11;
    else                exc_cause = 4'd0;
  end

  // Output register: loads pop the FIFO, a stalled bundle holds every field.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_valid_o       <= 1'b0;
      dec_pc_o          <= '0;
      dec_rd_v_o        <= 1'b0;
      dec_rs1_v_o       <= 1'b0;
      dec_rs2_v_o       <= 1'b0;
      dec_rd_adr_o      <= '0;
      dec_rs1_adr_o     <= '0;
      dec_rs2_adr_o     <= '0;
      dec_imm_o         <= '0;
      dec_unit_o        <= '0;
      dec_op_o          <= '0;
      dec_access_size_o <= '0;
      dec_unsigned_o    <= 1'b0;
      dec_word_op_o     <= 1'b0;
      dec_csr_adr_o     <= '0;
      dec_exc_v_o       <= 1'b0;
      dec_exc_cause_o   <= '0;
    end else if (flush_i) begin
      dec_valid_o <= 1'b0;
    end else if (load) begin
      dec_valid_o       <= 1'b1;
      dec_pc_o          <= hi_pc;
      dec_rd_v_o        <= d_rd_v && !exc_v;
      dec_rs1_v_o       <= d_rs1_v && (rs1 != 5'd0) && !exc_v;
      dec_rs2_v_o       <= d_rs2_v && (rs2 != 5'd0) && !exc_v;
      dec_rd_adr_o      <= rd;
      dec_rs1_adr_o     <= rs1;
      dec_rs2_adr_o     <= rs2;
      dec_imm_o         <= d_imm[XLEN-1:0];
      dec_unit_o        <= d_unit;
      dec_op_o          <= d_op;
      dec_access_size_o <= d_size;
      dec_unsigned_o    <= d_unsigned;
      dec_word_op_o     <= d_word;
      dec_csr_adr_o     <= d_csr;
      dec_exc_v_o       <= exc_v;
      dec_exc_cause_o   <= exc_cause;
    end else if (dec_ready_i) begin
      dec_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_next;
  end

  // Trap bundles take precedence over serialising ones; only flush leaves TRAP_WAIT.
  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (load && exc_v)       state_next = TRAP_WAIT;
          else if (load && serial) state_next = SER_WAIT;
        end
        SER_WAIT: if (serialize_done_i) state_next = RUN;
        default:  state_next = TRAP_WAIT;
      endcase
    end
  end

`ifdef DECODE_PERF_CNT_EN
  // Free-running counters; they wrap and survive flushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_dec_cnt_o   <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (load)                perf_dec_cnt_o   <= perf_dec_cnt_o + XLEN'(1);
      if (!fifo_empty && !load) perf_stall_cnt_o <= perf_stall_cnt_o + XLEN'(1);
    end
  end
`else
  // Without the performance counters there is nothing extra to build.
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//
// Directed bench for decode_stage. Two instances share the stimulus:
// one with XLEN=32 (main checks) and one with XLEN=64 (W-ops, ld).

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        serialize_done = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [63:0] if_pc = '0;
  logic        if_fault = 1'b0;
  logic        dec_ready = 1'b0;

  logic        d32_if_ready, d32_valid, d32_rd_v, d32_rs1_v, d32_rs2_v;
  logic [31:0] d32_pc, d32_imm;
  logic [4:0]  d32_rd, d32_rs1, d32_rs2;
  logic [5:0]  d32_unit, d32_op;
  logic [3:0]  d32_size, d32_cause;
  logic        d32_unsigned, d32_word, d32_exc;
  logic [11:0] d32_csr;

  logic        d64_if_ready, d64_valid, d64_rd_v, d64_rs1_v, d64_rs2_v;
  logic [63:0] d64_pc, d64_imm;
  logic [4:0]  d64_rd, d64_rs1, d64_rs2;
  logic [5:0]  d64_unit, d64_op;
  logic [3:0]  d64_size, d64_cause;
  logic        d64_unsigned, d64_word, d64_exc;
  logic [11:0] d64_csr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush_i(flush), .serialize_done_i(serialize_done),
    .if_valid_i(if_valid), .if_ready_o(d32_if_ready), .if_instr_i(if_instr),
    .if_pc_i(if_pc[31:0]), .if_fault_i(if_fault),
    .dec_valid_o(d32_valid), .dec_ready_i(dec_ready), .dec_pc_o(d32_pc),
    .dec_rd_v_o(d32_rd_v), .dec_rs1_v_o(d32_rs1_v), .dec_rs2_v_o(d32_rs2_v),
    .dec_rd_adr_o(d32_rd), .dec_rs1_adr_o(d32_rs1), .dec_rs2_adr_o(d32_rs2),
    .dec_imm_o(d32_imm), .dec_unit_o(d32_unit), .dec_op_o(d32_op),
    .dec_access_size_o(d32_size), .dec_unsigned_o(d32_unsigned), .dec_word_op_o(d32_word),
    .dec_csr_adr_o(d32_csr), .dec_exc_v_o(d32_exc), .dec_exc_cause_o(d32_cause)
  );

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush_i(flush), .serialize_done_i(serialize_done),
    .if_valid_i(if_valid), .if_ready_o(d64_if_ready), .if_instr_i(if_instr),
    .if_pc_i(if_pc), .if_fault_i(if_fault),
    .dec_valid_o(d64_valid), .dec_ready_i(dec_ready), .dec_pc_o(d64_pc),
    .dec_rd_v_o(d64_rd_v), .dec_rs1_v_o(d64_rs1_v), .dec_rs2_v_o(d64_rs2_v),
    .dec_rd_adr_o(d64_rd), .dec_rs1_adr_o(d64_rs1), .dec_rs2_adr_o(d64_rs2),
    .dec_imm_o(d64_imm), .dec_unit_o(d64_unit), .dec_op_o(d64_op),
    .dec_access_size_o(d64_size), .dec_unsigned_o(d64_unsigned), .dec_word_op_o(d64_word),
    .dec_csr_adr_o(d64_csr), .dec_exc_v_o(d64_exc), .dec_exc_cause_o(d64_cause)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction to fetch for exactly one edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic [63:0] pc, input logic fault);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    if_fault = fault;
    tick();
    if_valid = 1'b0;
    if_fault = 1'b0;
  endtask

  task automatic flushStage();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    $display("[TB] decode_stage directed test start");
    tick();
    tick();
    checkOutput("reset_valid", d32_valid, 0);
    checkOutput("reset_if_ready", d32_if_ready, 1);
    checkOutput("reset_pc", d32_pc, 0);
    checkOutput("reset_unit", d32_unit, 0);
    reset_n = 1'b1;
    tick();

    // addi x1,x0,5
    dec_ready = 1'b1;
    applyStimulus(32'h0050_0093, 64'h100, 1'b0);
    checkOutput("addi_no_bypass", d32_valid, 0);
    tick();
    checkOutput("addi_valid", d32_valid, 1);
    checkOutput("addi_rd", d32_rd, 1);
    checkOutput("addi_rd_v", d32_rd_v, 1);
    checkOutput("addi_rs1_v", d32_rs1_v, 0);
    checkOutput("addi_imm", d32_imm, 5);
    checkOutput("addi_pc", d32_pc, 64'h100);
    checkOutput("addi_unit", d32_unit, 6'b000001);
    checkOutput("addi_op", d32_op, 6'b000001);
    checkOutput("addi_exc", d32_exc, 0);
    tick();
    checkOutput("addi_drained", d32_valid, 0);

    // Five back-to-back pushes into a stalled stage
    dec_ready = 1'b0;
    for (int k = 1; k <= 5; k++)
      applyStimulus((32'(k) << 20) | (32'(k) << 7) | 32'h13, 64'h200 + 64'(4 * k), 1'b0);
    checkOutput("full_if_ready", d32_if_ready, 0);
    checkOutput("full_valid", d32_valid, 1);
    checkOutput("full_hold_pc", d32_pc, 64'h204);
    checkOutput("full_hold_rd", d32_rd, 1);
    // A sixth word offered while full must be refused even though a pop happens now
    if_valid  = 1'b1;
    if_instr  = 32'h0060_0313;
    if_pc     = 64'h218;
    dec_ready = 1'b1;
    tick();
    if_valid = 1'b0;
    checkOutput("drain_pc_2", d32_pc, 64'h208);
    checkOutput("drain_if_ready", d32_if_ready, 1);
    for (int k = 3; k <= 5; k++) begin
      tick();
      checkOutput("drain_valid", d32_valid, 1);
      checkOutput("drain_pc", d32_pc, 64'h200 + 64'(4 * k));
    end
    tick();
    checkOutput("drain_refused_6th", d32_valid, 0);

    // csrrw x2,mstatus,x1 then add x3,x1,x2
    applyStimulus(32'h3000_9173, 64'h300, 1'b0);
    applyStimulus(32'h0020_81B3, 64'h304, 1'b0);
    checkOutput("csr_valid", d32_valid, 1);
    checkOutput("csr_adr", d32_csr, 12'h300);
    checkOutput("csr_unit", d32_unit, 6'b100000);
    checkOutput("csr_op", d32_op, 6'b000001);
    checkOutput("csr_rs1_v", d32_rs1_v, 1);
    tick();
    checkOutput("ser_stall_1", d32_valid, 0);
    tick();
    checkOutput("ser_stall_2", d32_valid, 0);
    serialize_done = 1'b1;
    tick();
    serialize_done = 1'b0;
    checkOutput("ser_release_edge", d32_valid, 0);
    tick();
    checkOutput("add_valid", d32_valid, 1);
    checkOutput("add_pc", d32_pc, 64'h304);
    checkOutput("add_rs2_v", d32_rs2_v, 1);
    checkOutput("add_rd", d32_rd, 3);
    tick();

    // Illegal word traps and ignores serialize_done until a flush
    applyStimulus(32'hFFFF_FFFF, 64'h400, 1'b0);
    applyStimulus(32'h0070_0393, 64'h404, 1'b0);
    checkOutput("ill_exc", d32_exc, 1);
    checkOutput("ill_cause", d32_cause, 2);
    checkOutput("ill_rd_v", d32_rd_v, 0);
    tick();
    checkOutput("trap_stall", d32_valid, 0);
    serialize_done = 1'b1;
    tick();
    serialize_done = 1'b0;
    tick();
    checkOutput("trap_ignores_done", d32_valid, 0);
    flushStage();
    tick();
    checkOutput("flush_emptied", d32_valid, 0);
    applyStimulus(32'h0090_0493, 64'h500, 1'b0);
    tick();
    checkOutput("post_flush_valid", d32_valid, 1);
    checkOutput("post_flush_pc", d32_pc, 64'h500);
    checkOutput("post_flush_rd", d32_rd, 9);
    checkOutput("post_flush_exc", d32_exc, 0);
    tick();

    // addw and ld: legal on RV64, illegal on RV32
    applyStimulus(32'h0020_81BB, 64'h600, 1'b0);
    tick();
    checkOutput("addw64_word_op", d64_word, 1);
    checkOutput("addw64_exc", d64_exc, 0);
    checkOutput("addw64_rd", d64_rd, 3);
    checkOutput("addw32_cause", d32_cause, 2);
    checkOutput("addw32_exc", d32_exc, 1);
    flushStage();
    applyStimulus(32'h0000_B103, 64'h604, 1'b0);
    tick();
    checkOutput("ld64_size", d64_size, 4'b1000);
    checkOutput("ld64_exc", d64_exc, 0);
    checkOutput("ld64_unit", d64_unit, 6'b001000);
    checkOutput("ld32_cause", d32_cause, 2);
    flushStage();

    // Exception cause priority
    applyStimulus(32'h0000_0073, 64'h700, 1'b1);
    tick();
    checkOutput("fault_ecall_cause", d32_cause, 1);
    checkOutput("fault_ecall_exc", d32_exc, 1);
    flushStage();
    applyStimulus(32'h0000_0073, 64'h704, 1'b0);
    tick();
    checkOutput("ecall_cause", d32_cause, 11);
    flushStage();
    applyStimulus(32'h0010_0073, 64'h708, 1'b0);
    tick();
    checkOutput("ebreak_cause", d32_cause, 3);
    flushStage();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
